ws2812_rx: RTL and testbench
============================

// Module: ws2812_rx
// PURPOSE
//  Receive-side counterpart of our WS2812B transmit path: decodes a single-wire
//  WS2812B serial stream (GRB, MSB first, pulse-width coded) back into 24-bit pixels.
//  Used to loop back and check our own LED driver output, and to act as a "virtual
//  LED" that latches one addressed pixel on each frame reset. Sits on a board input
//  pin; all logic runs in the CLOCK_50 domain.
// PARAMETERS
//  RESET_CYCLES  2500  continuous low cycles (50 us @ 50 MHz) that end a frame
//  THRESH        30    high-pulse width >= THRESH decodes as 1, else 0 (T0H=20, T1H=40)
//  MIN_HIGH      8     high pulse shorter than this is a glitch -> error
//  MAX_HIGH      60    line high for this many cycles -> error (stuck high)
//  LATCH_INDEX   0     pixel index within a frame copied to led_g/r/b at frame end
//  IDX_W         10    width of pixel_index
// PORTS
//  CLOCK_50     in   1   system clock, 50 MHz
//  rst          in   1   asynchronous, active-high reset
//  din          in   1   WS2812B serial input (asynchronous to CLOCK_50)
//  pixel_g/r/b  out  8   each; most recently decoded pixel, valid with pixel_valid
//  pixel_valid  out  1   one-cycle pulse per complete 24-bit pixel
//  pixel_index  out  IDX_W  index of that pixel within the frame (0 = first)
//  frame_done   out  1   one-cycle pulse when a reset gap ends a frame
//  bit_error    out  1   one-cycle pulse on a timing violation or truncated pixel
//  led_g/r/b    out  8   each; latched colour of pixel LATCH_INDEX, updated at frame_done
// BEHAVIOUR
//  - rst: every output 0; FSM goes to HUNT. Decoding restarts from HUNT after rst
//    deasserts, regardless of where the line is in a frame.
//  - din passes through a 2-flop synchroniser plus a previous-value register for
//    edge detection. Registered outputs are fixed at 3 CLOCK_50 cycles after the
//    causing din edge.
//  - High-width counter and low-width counter are each 12 bits and saturate.
//  - FSM states:
//    HUNT: wait for din low for RESET_CYCLES consecutive cycles; any high sample
//      clears the count. When the count completes -> IDLE. No frame_done is issued.
//    IDLE: line low at a frame boundary; bit_cnt=0, pixel_index=0.
//      Rising edge -> HIGH.
//    HIGH: count high cycles.
//      Falling edge with width < MIN_HIGH -> bit_error, go to HUNT.
//      Otherwise shift in bit (width >= THRESH ? 1 : 0) and go to LOW.
//      Width reaches MAX_HIGH while still high -> bit_error, go to HUNT.
//    LOW: count low cycles.
//      Rising edge -> HIGH.
//      Low count reaches RESET_CYCLES -> frame_done, go to IDLE. If bit_cnt != 0,
//      also pulse bit_error in the same cycle and discard the partial pixel.
//  - Bit 24 of a pixel (bit_cnt wraps 23 -> 0) produces, registered together:
//    pixel_valid, pixel_g/r/b = bits[23:16]/[15:8]/[7:0], and pixel_index.
//    pixel_index then increments and saturates at all-ones (no wrap).
//  - If pixel_index == LATCH_INDEX when a pixel completes, the pixel goes into a
//    shadow register. At frame_done, led_* <- shadow only if the shadow was filled
//    in this frame; otherwise led_* hold their value.
//  - An error aborts the frame: no frame_done and no led_* update until a new
//    frame is decoded after HUNT.
//  - Frame-end arithmetic: the last low period lasts RESET_CYCLES+3 cycles after the
//    final falling edge before frame_done asserts.
// STRUCTURE
//  - ws2812_defs.vh (shared with the transmitter): the timing constants T0H=20,
//    T1H=40, TBIT=62, RESET_CYCLES=2500, and the GRB bit-field offsets.
//  - Sub-module ws2812_in_sync: 2-flop synchroniser plus rise/fall pulse outputs.
//    The FSM, counters, shift register and latch logic stay in ws2812_rx.
// TESTING
//  1. rst, 2500 low, then one pixel G=FF R=00 B=00 (T0H=20, T1H=40, period 62),
//     then 2600 low -> single pixel_valid with g=FF r=00 b=00, idx=0; frame_done
//     once; led_g=FF.
//  2. Three pixels 123456, ABCDEF, 000001 then a gap -> pixel_valid at idx 0,1,2
//     with matching fields; with LATCH_INDEX=1, led_g/r/b = AB/CD/EF after
//     frame_done.
//  3. Threshold: high widths 29 -> 0 and 30 -> 1; width 7 -> bit_error, then no
//     pixel_valid until after a 2500-cycle low.
//  4. 12 bits followed by a 2600-cycle low -> frame_done and bit_error in the
//     same cycle; no pixel_valid; led_* unchanged.
//  5. din held high for 100 cycles -> bit_error exactly 3 cycles after high
//     count 60; the next frame decodes only after 2500 low cycles.
//  6. rst asserted mid-pixel -> all outputs 0 immediately; bits sent before the
//     next 2500-cycle low are ignored; a following frame decodes normally.

Source files
------------

// File: rtl/ws2812_rx_pkg.sv
// Shared WS2812B timing constants, GRB field offsets and receiver state type.
package ws2812_rx_pkg;

  localparam int T0H              = 20;
  localparam int T1H              = 40;
  localparam int TBIT             = 62;
  localparam int DEF_RESET_CYCLES = 2500;
  localparam int CNT_W            = 12;

  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_in_sync.sv
// Two-flop synchroniser for the asynchronous data pin, plus a previous-sample
// flop so rise/fall pulses are one cycle wide and aligned with level_o.
module ws2812_in_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchroniser stages, [2] previous synchronised sample
  logic [2:0] pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[1:0], din_i};
    end
  end

  assign level_o = pipe_q[1];
  assign rise_o  = pipe_q[1] & ~pipe_q[2];
  assign fall_o  = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/ws2812_rx.sv
// WS2812B receiver: measures high-pulse widths to decode GRB bits into pixels,
// detects frame-reset gaps and latches one addressed pixel per frame.
module ws2812_rx
  import ws2812_rx_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int THRESH       = (T0H + T1H) / 2,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = TBIT - 2,
  parameter int LATCH_INDEX  = 0,
  parameter int IDX_W        = 10
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             din,
  output logic [7:0]       pixel_g,
  output logic [7:0]       pixel_r,
  output logic [7:0]       pixel_b,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             bit_error,
  output logic [7:0]       led_g,
  output logic [7:0]       led_r,
  output logic [7:0]       led_b
);

  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH);
  localparam logic [IDX_W-1:0] LATCH_C  = IDX_W'(LATCH_INDEX);

  logic level, rise, fall;

  ws2812_in_sync u_sync (
    .clk_i   (CLOCK_50),
    .rst_i   (rst),
    .din_i   (din),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] hcnt_q, lcnt_q;
  logic [4:0]       bit_cnt_q;
  logic [22:0]      sr_q;
  logic [IDX_W-1:0] idx_q;
  logic [23:0]      shadow_q;
  logic             shadow_ok_q;

  logic        bit_d;
  logic [23:0] sr_d;

  // The width is complete on the fall cycle: hcnt_q then equals high samples seen.
  assign bit_d = (hcnt_q >= THRESH_C);
  assign sr_d  = {sr_q, bit_d};

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_ok_q <= 1'b0;
      pixel_g     <= '0;
      pixel_r     <= '0;
      pixel_b     <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      led_g       <= '0;
      led_r       <= '0;
      led_b       <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          lcnt_q <= level ? '0 : sat_inc(lcnt_q);
          if (!level && lcnt_q >= RESET_C) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            shadow_ok_q <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_HIGH;
            hcnt_q  <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            if (hcnt_q < MIN_C) begin
              bit_error <= 1'b1;
              lcnt_q    <= '0;
              state_q   <= ST_HUNT;
            end else begin
              sr_q    <= sr_d[22:0];
              lcnt_q  <= CNT_W'(1);
              state_q <= ST_LOW;
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q   <= '0;
                pixel_valid <= 1'b1;
                pixel_g     <= sr_d[G_OFS +: 8];
                pixel_r     <= sr_d[R_OFS +: 8];
                pixel_b     <= sr_d[B_OFS +: 8];
                pixel_index <= idx_q;
                if (!(&idx_q)) idx_q <= idx_q + IDX_W'(1);
                if (idx_q == LATCH_C) begin
                  shadow_q    <= sr_d;
                  shadow_ok_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end else if (hcnt_q >= MAX_C) begin
            bit_error <= 1'b1;
            lcnt_q    <= '0;
            state_q   <= ST_HUNT;
          end else begin
            hcnt_q <= sat_inc(hcnt_q);
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_q <= ST_HIGH;
            hcnt_q  <= CNT_W'(1);
          end else if (lcnt_q >= RESET_C) begin
            // Frame ends here; a partial pixel is dropped but still flagged.
            frame_done  <= 1'b1;
            bit_error   <= (bit_cnt_q != 5'd0);
            if (shadow_ok_q) begin
              led_g <= shadow_q[G_OFS +: 8];
              led_r <= shadow_q[R_OFS +: 8];
              led_b <= shadow_q[B_OFS +: 8];
            end
            shadow_ok_q <= 1'b0;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            state_q     <= ST_IDLE;
          end else begin
            lcnt_q <= sat_inc(lcnt_q);
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: event-level reference model of the pulse
// coding rules, directed scenarios, a threshold vector table and random frames.
module tb_ws2812_rx;
  import ws2812_rx_pkg::*;

  localparam int RST_C  = 2500;
  localparam int THRESH = 30;
  localparam int MIN_H  = 8;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  logic [7:0] g0, r0, b0, lg0, lr0, lb0;
  logic [7:0] g1, r1, b1, lg1, lr1, lb1;
  logic       pv0, fd0, be0, pv1, fd1, be1;
  logic [9:0] idx0, idx1;

  ws2812_rx #(.LATCH_INDEX(0)) dut0 (
    .CLOCK_50(clk), .rst(rst), .din(din),
    .pixel_g(g0), .pixel_r(r0), .pixel_b(b0), .pixel_valid(pv0),
    .pixel_index(idx0), .frame_done(fd0), .bit_error(be0),
    .led_g(lg0), .led_r(lr0), .led_b(lb0)
  );

  ws2812_rx #(.LATCH_INDEX(1)) dut1 (
    .CLOCK_50(clk), .rst(rst), .din(din),
    .pixel_g(g1), .pixel_r(r1), .pixel_b(b1), .pixel_valid(pv1),
    .pixel_index(idx1), .frame_done(fd1), .bit_error(be1),
    .led_g(lg1), .led_r(lr1), .led_b(lb1)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [23:0] pix;
    int          idx;
  } pv_t;

  pv_t got_pv[$];
  pv_t exp_pv[$];
  int  got_fd[$], exp_fd[$], got_be[$], exp_be[$];

  always @(negedge clk) begin : mon
    pv_t e;
    if (pv0) begin
      e.cyc = cyc;
      e.pix = {g0, r0, b0};
      e.idx = int'(idx0);
      got_pv.push_back(e);
    end
    if (fd0) got_fd.push_back(cyc);
    if (be0) got_be.push_back(cyc);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference model state: what the decoder should have seen so far
  bit          hunting;
  bit          mactive;
  int          mbits;
  int          midx;
  int          last_fall;
  logic [23:0] msr;
  logic [23:0] sh_val[2];
  bit          sh_ok[2];
  logic [23:0] led_exp[2];

  task automatic clear_frame();
    mbits   = 0;
    midx    = 0;
    mactive = 0;
    for (int k = 0; k < 2; k++) sh_ok[k] = 0;
  endtask

  task automatic abort_frame();
    clear_frame();
    hunting = 1;
  endtask

  task automatic low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int w, input int gap);
    pv_t e;
    din = 1'b1;
    repeat (w) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    if (!hunting) begin
      if (w < MIN_H) begin
        exp_be.push_back(cyc + LAT);
        abort_frame();
      end else begin
        mactive = 1;
        msr = {msr[22:0], 1'(w >= THRESH)};
        mbits++;
        if (mbits == 24) begin
          e.cyc = cyc + LAT;
          e.pix = msr;
          e.idx = midx;
          exp_pv.push_back(e);
          if (midx < 2) begin
            sh_val[midx] = msr;
            sh_ok[midx]  = 1;
          end
          midx++;
          mbits = 0;
        end
      end
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] v, input int nbits);
    int w;
    for (int i = nbits - 1; i >= 0; i--) begin
      w = v[i] ? T1H : T0H;
      send_bit(w, TBIT - w);
    end
  endtask

  task automatic end_frame();
    din = 1'b0;
    if (!hunting && mactive) begin
      exp_fd.push_back(last_fall + RST_C + LAT);
      if (mbits != 0) exp_be.push_back(last_fall + RST_C + LAT);
      for (int k = 0; k < 2; k++) if (sh_ok[k]) led_exp[k] = sh_val[k];
    end
    clear_frame();
    hunting = 0;
    low(RST_C + 100);
  endtask

  task automatic stuck_high(input int n);
    din = 1'b1;
    if (!hunting) begin
      exp_be.push_back(cyc + 60 + LAT);
      abort_frame();
    end
    repeat (n) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset outputs dut0", {g0, r0, b0, pv0, idx0, fd0, be0, lg0, lr0, lb0}, 0);
    check("reset outputs dut1", {g1, r1, b1, pv1, idx1, fd1, be1, lg1, lr1, lb1}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    abort_frame();
    for (int k = 0; k < 2; k++) led_exp[k] = '0;
  endtask

  task automatic compare(input string tag);
    int n;
    check($sformatf("%s pixel count", tag), got_pv.size(), exp_pv.size());
    n = (got_pv.size() < exp_pv.size()) ? got_pv.size() : exp_pv.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s pixel%0d cycle", tag, i), got_pv[i].cyc, exp_pv[i].cyc);
      check($sformatf("%s pixel%0d grb", tag, i), got_pv[i].pix, exp_pv[i].pix);
      check($sformatf("%s pixel%0d index", tag, i), got_pv[i].idx, exp_pv[i].idx);
    end
    check($sformatf("%s frame_done count", tag), got_fd.size(), exp_fd.size());
    n = (got_fd.size() < exp_fd.size()) ? got_fd.size() : exp_fd.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s frame_done%0d cycle", tag, i), got_fd[i], exp_fd[i]);
    check($sformatf("%s bit_error count", tag), got_be.size(), exp_be.size());
    n = (got_be.size() < exp_be.size()) ? got_be.size() : exp_be.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s bit_error%0d cycle", tag, i), got_be[i], exp_be[i]);
    check($sformatf("%s led latch0", tag), {lg0, lr0, lb0}, led_exp[0]);
    check($sformatf("%s led latch1", tag), {lg1, lr1, lb1}, led_exp[1]);
    got_pv.delete(); exp_pv.delete();
    got_fd.delete(); exp_fd.delete();
    got_be.delete(); exp_be.delete();
  endtask

  typedef struct {
    int w;
    bit exp_err;
    bit exp_bit;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #(5ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{29, 1'b0, 1'b0};
    vecs[1] = '{30, 1'b0, 1'b1};
    vecs[2] = '{ 8, 1'b0, 1'b0};
    vecs[3] = '{59, 1'b0, 1'b1};
    vecs[4] = '{ 7, 1'b1, 1'b0};
    vecs[5] = '{20, 1'b0, 1'b0};
    vecs[6] = '{40, 1'b0, 1'b1};
    msr = '0;
    last_fall = 0;

    repeat (2) @(negedge clk);
    do_reset();

    // Single pixel after the initial hunt
    end_frame();
    send_word(24'hFF0000, 24);
    end_frame();
    compare("t1");
    $display("t1 single pixel done at cycle %0d", cyc);

    send_word(24'h123456, 24);
    send_word(24'hABCDEF, 24);
    send_word(24'h000001, 24);
    end_frame();
    compare("t2");
    $display("t2 three pixels done at cycle %0d", cyc);

    for (int i = 0; i < 7; i++) begin
      send_bit(vecs[i].w, TBIT - vecs[i].w);
      if (vecs[i].exp_err) begin
        send_word(24'hC3C3C3, 24);
        end_frame();
        check($sformatf("t3 w=%0d error seen", vecs[i].w), got_be.size(), 1);
      end else begin
        send_word(24'h2A5A5A, 23);
        low(8);
        check($sformatf("t3 w=%0d decoded msb", vecs[i].w),
              (got_pv.size() > 0) ? longint'(got_pv[got_pv.size()-1].pix[23]) : -1,
              vecs[i].exp_bit);
      end
      compare($sformatf("t3 vec%0d", i));
      $display("t3 width %0d applied at cycle %0d", vecs[i].w, cyc);
    end
    end_frame();
    compare("t3 end");

    send_word(24'h000ABC, 12);
    end_frame();
    compare("t4");
    $display("t4 truncated pixel done at cycle %0d", cyc);

    stuck_high(100);
    low(100);
    send_word(24'h55AA55, 24);
    end_frame();
    send_word(24'h0F0F0F, 24);
    end_frame();
    compare("t5");
    $display("t5 stuck high done at cycle %0d", cyc);

    send_word(24'h3C3C3C, 10);
    do_reset();
    send_word(24'h3C3C3C, 10);
    end_frame();
    send_word(24'h808001, 24);
    end_frame();
    compare("t6");
    $display("t6 mid-pixel reset done at cycle %0d", cyc);

    for (int f = 0; f < 3; f++) begin
      int npix;
      npix = $urandom_range(1, 2);
      for (int p = 0; p < npix * 24 + ((f == 1) ? 9 : 0); p++) begin
        int w;
        w = ($urandom_range(0, 1) == 1) ? $urandom_range(THRESH, 55)
                                        : $urandom_range(MIN_H, THRESH - 1);
        send_bit(w, $urandom_range(3, 30));
      end
      end_frame();
      compare($sformatf("rnd%0d", f));
      $display("random frame %0d (%0d pixels) done at cycle %0d", f, npix, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
